// File: rtl/depacketizer.sv
// MIX-mode receive framer: hunts the alternating preamble, locks on the
// phase-flip sync pair, decodes mode/length and emits the payload on AXIS.
module depacketizer #(
  parameter int BYTES   = 1,
  parameter int PRE_MIN = 64,
  parameter int TIMEOUT = 1023,
  localparam int BITS   = BYTES * 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      MODE_CTRL,
  input  logic [BITS-1:0] I_tdata,
  input  logic            I_tvalid,
  input  logic            I_tuser,
  output logic [BITS-1:0] O_tdata,
  output logic            O_tvalid,
  output logic            O_tlast,
  output logic            O_tuser,
  output logic [15:0]     payload_length,
  output logic            hdr_vld,
  output logic            pld_vld,
  output logic            pkt_rcvd,
  output logic            pkt_err
);

  typedef enum logic [2:0] {
    HUNT,
    SKIP,
    MODE,
    LEN,
    TAIL,
    PLD
  } state_t;

  localparam logic [3:0] MIX    = 4'b0100;
  localparam logic [7:0] AC_MAX = 8'(PRE_MIN);
  localparam logic [9:0] TC_MAX = 10'(TIMEOUT - 1);

  state_t      state;
  logic [8:0]  hp;
  logic [15:0] pc;
  logic [15:0] len;
  logic [15:0] nsym;
  logic [7:0]  ac;
  logic [3:0]  m;
  logic [9:0]  tc;
  logic        prev;
  logic        is_bpsk;
  logic        mix_q;

  logic        mix;
  logic        b;
  logic        match;
  logic        sync;
  logic        last_beat;
  logic        tmo;
  logic [3:0]  m_next;
  logic [15:0] len_next;
  logic [15:0] nsym_next;
  logic [15:0] pc_inc;
  logic [7:0]  ac_inc;

  assign mix       = (MODE_CTRL == MIX);
  assign b         = I_tdata[0];
  // Expected mode pattern is 1,0,1,0...: even header positions carry 1.
  assign match     = (b == ~hp[0]);
  assign m_next    = m + 4'(match);
  assign len_next  = {len[14:0], b};
  assign nsym_next = is_bpsk ? len_next : (len_next >> 1);
  assign pc_inc    = pc + 16'd1;
  assign last_beat = (pc_inc == nsym);
  assign tmo       = (tc == TC_MAX);
  assign ac_inc    = (ac >= AC_MAX) ? ac : ac + 8'd1;
  assign sync      = b && prev && (ac >= AC_MAX);

  // mix_q resets high so that pld_vld reads 0 out of reset.
  assign hdr_vld = mix_q && ((state == SKIP) || (state == MODE) ||
                             (state == LEN)  || (state == TAIL));
  assign pld_vld = !mix_q || (state == PLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HUNT;
      hp             <= '0;
      pc             <= '0;
      len            <= '0;
      nsym           <= '0;
      ac             <= '0;
      m              <= '0;
      tc             <= '0;
      prev           <= 1'b0;
      is_bpsk        <= 1'b0;
      mix_q          <= 1'b1;
      O_tdata        <= '0;
      O_tvalid       <= 1'b0;
      O_tlast        <= 1'b0;
      O_tuser        <= 1'b1;
      payload_length <= '0;
      pkt_rcvd       <= 1'b0;
      pkt_err        <= 1'b0;
    end else begin
      O_tvalid <= 1'b0;
      O_tlast  <= 1'b0;
      pkt_rcvd <= 1'b0;
      pkt_err  <= 1'b0;
      mix_q    <= mix;
      if (!mix) begin
        state    <= HUNT;
        hp       <= '0;
        pc       <= '0;
        ac       <= '0;
        m        <= '0;
        tc       <= '0;
        prev     <= 1'b0;
        O_tdata  <= I_tdata;
        O_tvalid <= I_tvalid;
        O_tuser  <= I_tuser;
      end else if (!I_tvalid) begin
        if (state != HUNT) begin
          if (tmo) begin
            state   <= HUNT;
            pkt_err <= 1'b1;
            tc      <= '0;
            ac      <= '0;
          end else begin
            tc <= tc + 10'd1;
          end
        end
      end else begin
        tc   <= '0;
        prev <= b;
        unique case (state)
          HUNT: begin
            if (sync) begin
              state <= SKIP;
              hp    <= 9'd225;
              ac    <= '0;
            end else if (b != prev) begin
              ac <= ac_inc;
            end else begin
              ac <= '0;
            end
          end
          SKIP: begin
            hp <= hp + 9'd1;
            if (hp == 9'd255) begin
              state <= MODE;
              m     <= '0;
            end
          end
          MODE: begin
            hp <= hp + 9'd1;
            m  <= m_next;
            if (hp == 9'd263) begin
              if (m_next >= 4'd5) begin
                is_bpsk <= 1'b1;
                state   <= LEN;
              end else if (m_next <= 4'd3) begin
                is_bpsk <= 1'b0;
                state   <= LEN;
              end else begin
                pkt_err <= 1'b1;
                state   <= HUNT;
                ac      <= '0;
              end
            end
          end
          LEN: begin
            hp  <= hp + 9'd1;
            len <= len_next;
            if (hp == 9'd279) begin
              payload_length <= len_next;
              nsym           <= nsym_next;
              if (nsym_next == 16'd0) begin
                pkt_err <= 1'b1;
                state   <= HUNT;
                ac      <= '0;
              end else begin
                state <= TAIL;
              end
            end
          end
          TAIL: begin
            hp <= hp + 9'd1;
            if (hp == 9'd319) begin
              state <= PLD;
              pc    <= '0;
            end
          end
          PLD: begin
            O_tdata  <= I_tdata;
            O_tvalid <= 1'b1;
            O_tuser  <= is_bpsk;
            pc       <= pc_inc;
            if (last_beat) begin
              O_tlast  <= 1'b1;
              pkt_rcvd <= 1'b1;
              state    <= HUNT;
              ac       <= '0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
